// File: rtl/imm_splitter.sv
// imm_splitter: splits a full-width constant into ADDI-style or LUI/ORI-style immediate chunks
module imm_splitter #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  out_imm,
    output logic [1:0]        out_kind,
    output logic              out_last
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ONE  = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] LO   = 2'd3;
    logic [1:0]       state_q, state_d;
    logic [IMM_W-1:0] imm_q, imm_d, lo_q, lo_d;
    logic [1:0]       kind_q, kind_d;
    logic             last_q, last_d;
    logic             accept, advance, fits, in_hi;
    assign out_valid = state_q != IDLE;
    assign out_imm   = imm_q;
    assign out_kind  = kind_q;
    assign out_last  = last_q;
    assign advance   = out_valid & out_ready;
    assign in_ready  = (state_q == IDLE) | (advance & last_q);
    assign accept    = in_valid & in_ready;
    assign in_hi     = state_q == HI;
    // Upper bits all equal to the chunk sign bit means one sign-extended chunk suffices
    assign fits = (&in_data[DATA_W-1:IMM_W-1]) | ~(|in_data[DATA_W-1:IMM_W-1]);
    // Next chunk: a new constant wins (it only happens once the final chunk is leaving), else HI steps to LO
    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        kind_d  = kind_q;
        last_d  = last_q;
        lo_d    = lo_q;
        if (accept) begin
            state_d = fits ? ONE : HI;
            imm_d   = fits ? in_data[IMM_W-1:0] : in_data[DATA_W-1:IMM_W];
            kind_d  = fits ? 2'b00 : 2'b01;
            last_d  = fits;
            lo_d    = in_data[IMM_W-1:0];
        end else if (advance) begin
            state_d = in_hi ? LO : IDLE;
            imm_d   = in_hi ? lo_q : imm_q;
            kind_d  = in_hi ? 2'b10 : kind_q;
            last_d  = in_hi | last_q;
        end
    end
    // State and presented chunk; reset drops any pending lower chunk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            imm_q   <= '0;
            kind_q  <= 2'b00;
            last_q  <= 1'b0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
            kind_q  <= kind_d;
            last_q  <= last_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_imm_splitter.sv
// tb_imm_splitter: directed vectors plus stall, stream, reset and randomized scoreboard checks
module tb_imm_splitter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_imm;
    logic [1:0]  out_kind;
    logic        out_last;
    int checks = 0;
    int errors = 0;

    imm_splitter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_kind(out_kind), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          n;
        logic [15:0] imm0;
        logic [1:0]  k0;
        logic [15:0] imm1;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_chunk(input string nm, input logic [15:0] imm, input logic [1:0] k, input logic l);
        chk({nm, " valid"}, {31'b0, out_valid}, 32'd1);
        chk({nm, " chunk"}, {13'b0, out_imm, out_kind, out_last}, {13'b0, imm, k, l});
    endtask

    function automatic logic fits32(input logic [31:0] d);
        return (d[31:15] == 17'h1ffff) || (d[31:15] == 17'h0);
    endfunction

    vec_t vecs[8];
    logic [31:0] s_data[5];
    logic        s_valid[6];
    logic        s_rdy[6];
    logic [15:0] s_imm[5];
    logic [1:0]  s_kind[5];
    logic [31:0] q[$];
    logic        phase;
    logic [18:0] prev_chunk;
    logic        prev_stall;
    logic [31:0] front;
    logic [18:0] exp_chunk;
    int          r;

    initial begin
        vecs[0] = '{32'h0000_7FFF, 1, 16'h7FFF, 2'b00, 16'h0};
        vecs[1] = '{32'hFFFF_8000, 1, 16'h8000, 2'b00, 16'h0};
        vecs[2] = '{32'h0000_8000, 2, 16'h0000, 2'b01, 16'h8000};
        vecs[3] = '{32'hFFFF_7FFF, 2, 16'hFFFF, 2'b01, 16'h7FFF};
        vecs[4] = '{32'h0000_0000, 1, 16'h0000, 2'b00, 16'h0};
        vecs[5] = '{32'hFFFF_FFFF, 1, 16'hFFFF, 2'b00, 16'h0};
        vecs[6] = '{32'h1234_5678, 2, 16'h1234, 2'b01, 16'h5678};
        vecs[7] = '{32'hDEAD_BEEF, 2, 16'hDEAD, 2'b01, 16'hBEEF};
        s_data  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0002};
        s_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        s_rdy   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        s_imm   = '{16'h0001, 16'hFFFF, 16'hDEAD, 16'hBEEF, 16'h0002};
        s_kind  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00};

        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_imm", {16'b0, out_imm}, 32'd0);
        chk("reset out_kind", {30'b0, out_kind}, 32'd0);
        chk("reset out_last", {31'b0, out_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            #1 chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk_chunk($sformatf("vec%0d c0", i), vecs[i].imm0, vecs[i].k0, vecs[i].n == 1);
            if (vecs[i].n == 2) begin
                @(negedge clk);
                chk_chunk($sformatf("vec%0d c1", i), vecs[i].imm1, 2'b10, 1'b1);
            end
            @(negedge clk);
            chk($sformatf("vec%0d idle", i), {31'b0, out_valid}, 32'd0);
        end

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            in_data = 32'hCAFE_0000;
            chk_chunk($sformatf("stall hi %0d", k), 16'h1234, 2'b01, 1'b0);
            #1 chk($sformatf("stall in_ready %0d", k), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        chk_chunk("stall hi release", 16'h1234, 2'b01, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk_chunk("stall lo", 16'h5678, 2'b10, 1'b1);
        #1 chk("stall lo in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        chk("stall idle", {31'b0, out_valid}, 32'd0);

        for (int c = 0; c < 6; c++) begin
            if (c > 0) chk_chunk($sformatf("stream %0d", c - 1), s_imm[c-1], s_kind[c-1], s_kind[c-1] != 2'b01);
            #1 chk($sformatf("stream in_ready %0d", c), {31'b0, in_ready}, {31'b0, s_rdy[c]});
            in_valid = s_valid[c];
            if (c < 5) in_data = s_data[c];
            @(negedge clk);
        end
        chk("stream idle", {31'b0, out_valid}, 32'd0);

        in_valid = 1'b1;
        in_data  = 32'hABCD_1234;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_chunk("rst hi", 16'hABCD, 2'b01, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("rst async valid", {31'b0, out_valid}, 32'd0);
        chk("rst async imm", {16'b0, out_imm}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post rst valid %0d", k), {31'b0, out_valid}, 32'd0);
            chk($sformatf("post rst in_ready %0d", k), {31'b0, in_ready}, 32'd1);
        end

        phase = 1'b0;
        prev_stall = 1'b0;
        prev_chunk = '0;
        for (int it = 0; it < 3000; it++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (it < 2980) && ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 3);
            in_data = (r == 1) ? {{17{1'(r[0] ^ $urandom_range(0, 1))}}, 15'($urandom)} :
                      (r == 2) ? ((it % 4 == 0) ? 32'h0000_7FFF : (it % 4 == 1) ? 32'hFFFF_8000 :
                                  (it % 4 == 2) ? 32'h0000_8000 : 32'hFFFF_7FFF) : $urandom;
            #1;
            if (prev_stall)
                chk("rnd hold", {31'b0, out_valid, out_imm, out_kind, out_last}, {31'b0, 1'b1, prev_chunk});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd spurious chunk", {31'b0, out_valid}, 32'd0);
                end else begin
                    front = q[0];
                    exp_chunk = fits32(front) ? {front[15:0], 2'b00, 1'b1} :
                                phase ? {front[15:0], 2'b10, 1'b1} : {front[31:16], 2'b01, 1'b0};
                    chk("rnd chunk", {13'b0, out_imm, out_kind, out_last}, {13'b0, exp_chunk});
                    if (fits32(front) || phase) begin
                        void'(q.pop_front());
                        phase = 1'b0;
                    end else begin
                        phase = 1'b1;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
            prev_stall = out_valid && !out_ready;
            prev_chunk = {out_imm, out_kind, out_last};
            @(negedge clk);
        end
        chk("rnd drained", q.size(), 32'd0);
        chk("rnd final idle", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
